// File: rtl/clock_set_ctrl_if.sv
// Signal bundle between the button debouncers / 1 Hz divider and the
// clock mode controller. The master side produces the tick and button pulses
// and consumes the per-field enables; the slave side is the controller.
interface clock_set_ctrl_if #(
  parameter int NUM_FIELDS = 6,
  parameter int SEL_WIDTH  = 3
);
  logic                  tick_1hz;
  logic                  btn_mode;
  logic                  btn_next;
  logic                  btn_up;
  logic                  btn_down;
  logic [NUM_FIELDS-1:0] en_field;
  logic                  up;
  logic                  down;
  logic                  set_mode;
  logic [SEL_WIDTH-1:0]  sel_field;
  logic                  blink;

  modport master (
    output tick_1hz, btn_mode, btn_next, btn_up, btn_down,
    input  en_field, up, down, set_mode, sel_field, blink
  );

  modport slave (
    input  tick_1hz, btn_mode, btn_next, btn_up, btn_down,
    output en_field, up, down, set_mode, sel_field, blink
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// Mode controller for the century clock counter chain.
// RUN forwards the 1 Hz tick to the seconds enable; SET pauses timekeeping and
// turns up/down button pulses into single enable pulses for the selected field.
// Optional feature macro: SET_TIMEOUT_EN -- adds an idle-second counter that
// drops back to RUN after TIMEOUT_S ticks without any button activity.
module clock_set_ctrl #(
  parameter int NUM_FIELDS = 6,
  parameter int SEL_WIDTH  = 3,
  parameter int TIMEOUT_S  = 30,
  parameter int TO_WIDTH   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  clock_set_ctrl_if.slave  bus
);

  localparam logic [0:0] ST_RUN = 1'b0;
  localparam logic [0:0] ST_SET = 1'b1;
  localparam logic [SEL_WIDTH-1:0] LAST_SEL = SEL_WIDTH'(NUM_FIELDS - 1);

  // Refuse to elaborate with counters too narrow for the configured ranges.
  if (((2 ** SEL_WIDTH) < NUM_FIELDS) || ((2 ** TO_WIDTH) <= TIMEOUT_S)) begin : g_bad_params
    $error("clock_set_ctrl: SEL_WIDTH or TO_WIDTH too small for NUM_FIELDS/TIMEOUT_S");
  end

  logic [0:0]            state_q, state_d;
  logic [NUM_FIELDS-1:0] en_q, en_d;
  logic                  up_q, up_d;
  logic                  down_q, down_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic                  blink_q, blink_d;
  logic                  leave_set;
`ifdef SET_TIMEOUT_EN
  logic [TO_WIDTH-1:0]   idle_q, idle_d;
  logic                  any_btn;
  logic                  timeout_hit;
`endif

  // Next-state logic: mode button first, then field select, then up/down.
  always_comb begin
    state_d   = state_q;
    en_d      = '0;
    up_d      = up_q;
    down_d    = down_q;
    sel_d     = sel_q;
    blink_d   = blink_q;
    leave_set = 1'b0;
`ifdef SET_TIMEOUT_EN
    idle_d      = idle_q;
    any_btn     = bus.btn_mode | bus.btn_next | bus.btn_up | bus.btn_down;
    timeout_hit = 1'b0;
`endif
    case (state_q)
      ST_RUN: begin
        en_d[0] = bus.tick_1hz;
        up_d    = 1'b1;
        down_d  = 1'b0;
`ifdef SET_TIMEOUT_EN
        idle_d  = '0;
`endif
        if (bus.btn_mode) begin
          state_d = ST_SET;
          sel_d   = '0;
          blink_d = 1'b1;
        end
      end
      default: begin
        if (bus.tick_1hz) begin
          blink_d = ~blink_q;
        end
`ifdef SET_TIMEOUT_EN
        // A button pulse restarts the idle count and beats a terminal tick.
        if (any_btn) begin
          idle_d = '0;
        end else if (bus.tick_1hz) begin
          if (idle_q == TO_WIDTH'(TIMEOUT_S - 1)) begin
            timeout_hit = 1'b1;
            idle_d      = '0;
          end else begin
            idle_d = idle_q + TO_WIDTH'(1);
          end
        end
        leave_set = bus.btn_mode | timeout_hit;
`else
        leave_set = bus.btn_mode;
`endif
        if (leave_set) begin
          state_d = ST_RUN;
          sel_d   = '0;
          blink_d = 1'b0;
          up_d    = 1'b1;
          down_d  = 1'b0;
        end else if (bus.btn_next) begin
          sel_d   = (sel_q == LAST_SEL) ? '0 : sel_q + SEL_WIDTH'(1);
          blink_d = 1'b1;
        end else if (bus.btn_up ^ bus.btn_down) begin
          for (int i = 0; i < NUM_FIELDS; i++) begin
            en_d[i] = (sel_q == SEL_WIDTH'(i));
          end
          up_d   = bus.btn_up;
          down_d = bus.btn_down;
        end
      end
    endcase
  end

  // Output and state registers; reset drops straight back to RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      en_q    <= '0;
      up_q    <= 1'b1;
      down_q  <= 1'b0;
      sel_q   <= '0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      up_q    <= up_d;
      down_q  <= down_d;
      sel_q   <= sel_d;
      blink_q <= blink_d;
    end
  end

`ifdef SET_TIMEOUT_EN
  // Idle-second counter, only meaningful while in SET.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`endif

  assign bus.en_field  = en_q;
  assign bus.up        = up_q;
  assign bus.down      = down_q;
  assign bus.set_mode  = (state_q == ST_SET);
  assign bus.sel_field = sel_q;
  assign bus.blink     = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Testbench for clock_set_ctrl: directed sequences plus random button/tick
// traffic, checked by a scoreboard fed from a behavioural model.
module tb_clock_set_ctrl;

  localparam int NF = 6;
  localparam int SW = 3;
  localparam int TO = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  clock_set_ctrl_if #(.NUM_FIELDS(NF), .SEL_WIDTH(SW)) bus ();

  clock_set_ctrl #(
    .NUM_FIELDS(NF),
    .SEL_WIDTH (SW),
    .TIMEOUT_S (TO),
    .TO_WIDTH  (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int en;
    int up;
    int down;
    int setm;
    int sel;
    int blink;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;
  int   errCount   = 0;
  int   checkCount = 0;

  // Reference model state: plain integers describing the user-visible behaviour.
  int mSet, mSel, mBlink, mUp, mDown, mIdle;

  task automatic checkField(input string name, input int act, input int req);
    checkCount++;
    if (act != req) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e, input string tag);
    checkField({tag, ".en_field"},  int'(bus.en_field),  e.en);
    checkField({tag, ".up"},        int'(bus.up),        e.up);
    checkField({tag, ".down"},      int'(bus.down),      e.down);
    checkField({tag, ".set_mode"},  int'(bus.set_mode),  e.setm);
    checkField({tag, ".sel_field"}, int'(bus.sel_field), e.sel);
    checkField({tag, ".blink"},     int'(bus.blink),     e.blink);
  endtask

  function automatic exp_t modelOutputs(input int en);
    exp_t e;
    e.en    = en;
    e.up    = mUp;
    e.down  = mDown;
    e.setm  = mSet;
    e.sel   = mSel;
    e.blink = mBlink;
    return e;
  endfunction

  task automatic modelReset();
    mSet = 0; mSel = 0; mBlink = 0; mUp = 1; mDown = 0; mIdle = 0;
  endtask

  task automatic modelLeaveSet();
    mSet = 0; mSel = 0; mBlink = 0; mUp = 1; mDown = 0; mIdle = 0;
  endtask

  // One clock of the controller described in user terms.
  task automatic modelStep(input bit t, input bit m, input bit n, input bit u,
                           input bit d, output exp_t e);
    int en;
    bit timedOut;
    en = 0;
    timedOut = 0;
    if (mSet == 0) begin
      if (t) en = 1;
      mUp = 1; mDown = 0;
      if (m) begin
        mSet = 1; mSel = 0; mBlink = 1; mIdle = 0;
      end
    end else begin
      if (t) mBlink = 1 - mBlink;
`ifdef SET_TIMEOUT_EN
      if (m || n || u || d) mIdle = 0;
      else if (t) begin
        mIdle++;
        if (mIdle >= TO) timedOut = 1;
      end
`endif
      if (m || timedOut) modelLeaveSet();
      else if (n) begin
        mSel = (mSel + 1) % NF;
        mBlink = 1;
      end else if (u != d) begin
        en = 1 << mSel;
        mUp = u; mDown = d;
      end
    end
    e = modelOutputs(en);
  endtask

  task automatic applyStimulus(input bit t, input bit m, input bit n, input bit u, input bit d);
    exp_t e;
    @(negedge clk);
    bus.tick_1hz = t;
    bus.btn_mode = m;
    bus.btn_next = n;
    bus.btn_up   = u;
    bus.btn_down = d;
    modelStep(t, m, n, u, d, e);
    expQ.push_back(e);
    @(posedge clk);
    #2;
    bus.tick_1hz = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_next = 1'b0;
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
  endtask

  // Scoreboard monitor: compares the DUT against each queued expectation.
  always @(posedge clk) begin
    #1;
    if (expQ.size() > 0) begin
      monE = expQ.pop_front();
      checkOutput(monE, "cycle");
    end
  end

  initial begin
    exp_t rstE;
    rstE = '{en: 0, up: 1, down: 0, setm: 0, sel: 0, blink: 0};
    bus.tick_1hz = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_next = 1'b0;
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    modelReset();
    #12;
    checkOutput(rstE, "reset");
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] RUN tick forwarding");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
    end

    $display("[TB] SET select and increment");
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);

    $display("[TB] field wrap and decrement");
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);

    $display("[TB] simultaneous buttons and priority");
    applyStimulus(0, 0, 0, 1, 1);
    applyStimulus(0, 0, 1, 1, 0);
    applyStimulus(1, 0, 0, 1, 0);
    applyStimulus(0, 1, 0, 1, 0);
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);

`ifdef SET_TIMEOUT_EN
    $display("[TB] idle timeout");
    applyStimulus(0, 1, 0, 0, 0);
    for (int i = 0; i < TO; i++) begin
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
    end
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0);
    for (int i = 0; i < TO; i++) begin
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
    end
`endif

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom % 4) == 0, ($urandom % 16) == 0, ($urandom % 8) == 0,
                    ($urandom % 6) == 0, ($urandom % 6) == 0);
    end

    $display("[TB] asynchronous reset during SET");
    if (mSet == 0) applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput(rstE, "async_reset");
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      applyStimulus(($urandom % 3) == 0, ($urandom % 12) == 0, ($urandom % 6) == 0,
                    ($urandom % 5) == 0, ($urandom % 5) == 0);
    end

    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
    checkCount++;
    if (expQ.size() != 0) begin
      errCount++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Mode controller for the century clock counter chain.
- In RUN it forwards the 1 Hz tick to the seconds field so the cascade counts up.
- In SET it pauses timekeeping, selects one field (sec, min, hour, day, month, year), and turns debounced button pulses into single up/down enable pulses for that field.
- Sits between the button debouncers and the per-field counter enables (en_s etc.); the top level ORs en_field[i] with the carry pulse from field i-1.

Parameters:
NUM_FIELDS, 6, number of adjustable fields; index 0 = seconds, NUM_FIELDS-1 = most significant field.
SEL_WIDTH, 3, width of sel_field; must satisfy 2^SEL_WIDTH >= NUM_FIELDS.
TIMEOUT_S, 30, idle seconds in SET before auto-return to RUN (used only with SET_TIMEOUT_EN).
TO_WIDTH, 6, width of the idle-second counter; must satisfy 2^TO_WIDTH > TIMEOUT_S.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
tick_1hz  input  1  single-cycle pulse once per second
btn_mode  input  1  debounced single-cycle pulse: enter/leave SET
btn_next  input  1  debounced single-cycle pulse: select next field
btn_up  input  1  debounced single-cycle pulse: increment selected field
btn_down  input  1  debounced single-cycle pulse: decrement selected field
en_field  output  NUM_FIELDS  one-hot (or zero) enable pulse per field
up  output  1  count direction up, valid with en_field
down  output  1  count direction down, valid with en_field
set_mode  output  1  1 while in SET
sel_field  output  SEL_WIDTH  index of the selected field; 0 in RUN
blink  output  1  display blink phase for the selected field; 0 in RUN

Behaviour:
- Reset (async, rst_n=0): state RUN; en_field=0; up=1; down=0; set_mode=0; sel_field=0; blink=0; idle counter=0.
- All outputs are registered; every response appears 1 clk after the input pulse.
- Two states: RUN and SET. The selected field is held in sel_field.
- RUN:
  - en_field[0] = tick_1hz delayed 1 clk; all other bits 0; up=1, down=0.
  - btn_next, btn_up and btn_down are ignored.
  - btn_mode -> SET, sel_field=0, blink=1, idle counter=0.
  - A tick in the same cycle as btn_mode is still forwarded (en_field[0]=1 once), then the clock pauses.
- SET:
  - tick_1hz never reaches en_field. Each tick toggles blink.
  - btn_up alone -> en_field[sel_field]=1 for exactly 1 clk with up=1, down=0.
  - btn_down alone -> en_field[sel_field]=1 for exactly 1 clk with up=0, down=1.
  - btn_up and btn_down together -> ignored; en_field stays 0.
  - btn_next -> sel_field+1, wrapping from NUM_FIELDS-1 to 0; blink is forced to 1.
  - btn_mode -> RUN, sel_field=0, blink=0, up=1, down=0.
- Priority within one cycle: btn_mode > btn_next > btn_up/btn_down.
  - mode+up -> exit only, no enable pulse.
  - next+up -> field advances only, no enable pulse.
- Outside an enable pulse, up/down hold their last value in SET and are 1/0 in RUN.
- en_field is never multi-hot.
- Reset asserted mid-SET returns to RUN immediately; no enable pulse is emitted.

Optional Feature:
SET_TIMEOUT_EN
- Defined:
  - In SET, the idle counter increments on each tick_1hz.
  - Any btn_* pulse clears it to 0.
  - When the counter reaches TIMEOUT_S (on a tick), the controller returns to RUN next clk exactly as if btn_mode had been pressed.
  - A button pulse in the same cycle as the terminal tick wins: it clears the counter and no timeout occurs.
- Undefined: no idle counter exists; SET is left only by btn_mode or reset.

Test Plan:
- Reset, then 3 tick_1hz pulses in RUN -> 3 one-clk en_field=6'b000001 pulses, each 1 clk after its tick; up=1, down=0; set_mode=0.
- btn_mode, then btn_next x2, then btn_up -> set_mode=1, sel_field=2, one pulse en_field=6'b000100 with up=1; ticks during SET produce no en_field and toggle blink.
- In SET with sel_field=5: btn_next -> sel_field=0; btn_down -> en_field=6'b000001 with down=1, up=0.
- btn_up and btn_down in the same cycle -> no en_field pulse. btn_mode with btn_up in the same cycle -> RUN, no pulse, sel_field=0, blink=0.
- SET_TIMEOUT_EN, TIMEOUT_S=3: enter SET, 3 ticks with no buttons -> set_mode=0 1 clk after the 3rd tick. Repeat with btn_up on the 2nd tick -> set_mode stays 1 until 3 further idle ticks.
- rst_n pulled low mid-SET, asynchronous to clk -> outputs return to reset values without waiting for a clk edge.
